// File: rtl/gpu_arb_mux_n.sv
// gpu_arb_mux_n: registered N:1 valid/ready stream mux with round-robin or fixed-priority arbitration and packet lock
module gpu_arb_mux_n #(
  parameter int NUM_INPUTS = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ARB_MODE = 0
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic [NUM_INPUTS-1:0]                 i_valid,
  input  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] i_data,
  input  logic [NUM_INPUTS-1:0]                 i_last,
  output logic [NUM_INPUTS-1:0]                 o_ready,
  output logic                                  o_valid,
  output logic [DATA_WIDTH-1:0]                 o_data,
  output logic                                  o_last,
  output logic [$clog2(NUM_INPUTS)-1:0]         o_sel,
  input  logic                                  i_ready
);
  localparam int SW = $clog2(NUM_INPUTS);
  if (NUM_INPUTS < 2 || (NUM_INPUTS & (NUM_INPUTS - 1)) != 0) begin : g_bad_n
    $fatal(1, "gpu_arb_mux_n: NUM_INPUTS must be a power of two >= 2");
  end
  logic          locked;
  logic [SW-1:0] lock_idx, ptr, gnt, cand;
  logic          gnt_v, ld, acc;
  assign ld = !o_valid || i_ready;
  always_comb begin
    gnt = lock_idx;
    gnt_v = locked;
    cand = '0;
    if (!locked)
      for (int i = NUM_INPUTS; i >= 1; i--) begin
        cand = (ARB_MODE == 1) ? SW'(i - 1) : ptr + SW'(i);
        if (i_valid[cand]) begin
          gnt = cand;
          gnt_v = 1'b1;
        end
      end
  end
  assign acc = ld && gnt_v && i_valid[gnt];
  assign o_ready = (ld && gnt_v) ? {{(NUM_INPUTS-1){1'b0}}, 1'b1} << gnt : '0;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_data <= '0;
      o_last <= 1'b0;
      o_sel <= '0;
      locked <= 1'b0;
      lock_idx <= '0;
      ptr <= SW'(NUM_INPUTS - 1);
    end else if (ld) begin
      o_valid <= acc;
      if (acc) begin
        o_data <= i_data[gnt];
        o_last <= i_last[gnt];
        o_sel <= gnt;
        locked <= !i_last[gnt];
        lock_idx <= gnt;
        if (i_last[gnt]) ptr <= gnt;
      end
    end
  end
endmodule
